// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Prioritised IRQ controller that issues one-shot PC takes to the
//               control unit. Define INTC_EDGE_EN for rising-edge capture.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter int         N_IRQ      = 4,
    parameter logic [9:0] VEC_BASE   = 10'h3C0,
    parameter int         VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             enable_pc,
    input  logic             reti,
    input  logic             ie_we,
    input  logic             ie_wdata,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic             int_take,
    output logic [9:0]       int_vector,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending
);

    localparam int         c_IDX_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_TAKE    = 2'd1;
    localparam logic [1:0] c_SERVICE = 2'd2;

    logic [1:0]         r_state;
    logic [N_IRQ-1:0]   r_mask;
    logic               r_ie;
    logic [c_IDX_W-1:0] r_sel_idx;

    logic [N_IRQ-1:0]   w_cand;
    logic [N_IRQ-1:0]   w_set;
    logic [N_IRQ-1:0]   w_clr;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_found;
    logic [9:0]         w_vector;

`ifdef INTC_EDGE_EN
    logic [N_IRQ-1:0]   r_irq_d;

    always_ff @(posedge clk) begin
        if (reset) r_irq_d <= '0;
        else       r_irq_d <= irq;
    end

    assign w_set = irq & ~r_irq_d;
`else
    assign w_set = irq;
`endif

    always_comb begin
        w_cand  = pending & r_mask;
        w_found = |w_cand;
        w_sel   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) w_sel = c_IDX_W'(i);
        end
        w_vector = VEC_BASE + 10'(w_sel) * 10'(VEC_STRIDE);
        w_clr    = '0;
        if (r_state == c_TAKE && enable_pc) w_clr[r_sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            pending    <= '0;
            r_mask     <= '0;
            r_ie       <= 1'b0;
            r_sel_idx  <= '0;
            int_take   <= 1'b0;
            int_vector <= '0;
            in_service <= 1'b0;
        end else begin
            // A new capture on the same bit as a completing take wins.
            pending <= (pending & ~w_clr) | w_set;
            if (ie_we)   r_ie   <= ie_wdata;
            if (mask_we) r_mask <= mask_wdata;
            case (r_state)
                c_IDLE: begin
                    if (r_ie && w_found) begin
                        r_sel_idx  <= w_sel;
                        int_vector <= w_vector;
                        int_take   <= 1'b1;
                        r_state    <= c_TAKE;
                    end
                end
                c_TAKE: begin
                    if (enable_pc) begin
                        int_take   <= 1'b0;
                        in_service <= 1'b1;
                        r_state    <= c_SERVICE;
                    end
                end
                c_SERVICE: begin
                    if (reti) begin
                        in_service <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed bench for interrupt_controller with a cycle model and
//               hand-computed spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       enable_pc;
    logic       reti;
    logic       ie_we;
    logic       ie_wdata;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       int_take;
    logic [9:0] int_vector;
    logic       in_service;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    interrupt_controller #(
        .N_IRQ     (4),
        .VEC_BASE  (10'h3C0),
        .VEC_STRIDE(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .enable_pc (enable_pc),
        .reti      (reti),
        .ie_we     (ie_we),
        .ie_wdata  (ie_wdata),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .int_take  (int_take),
        .int_vector(int_vector),
        .in_service(in_service),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Behavioural model: phase 0 = waiting, 1 = offering a take, 2 = in an ISR.
    int         m_phase = 0;
    int         m_sel   = 0;
    bit   [3:0] m_pend  = 0;
    bit   [3:0] m_mask  = 0;
    bit         m_ie    = 0;
    bit   [3:0] m_irq_d = 0;
    int         m_vec   = 0;

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        bit         s_reset, s_en, s_reti, s_iewe, s_ied, s_mwe;
        bit   [3:0] s_irq, s_md, newly, done;
        forever begin
            @(posedge clk);
            s_reset = reset; s_irq = irq; s_en = enable_pc; s_reti = reti;
            s_iewe = ie_we; s_ied = ie_wdata; s_mwe = mask_we; s_md = mask_wdata;
            #1;
            if (s_reset) begin
                m_phase = 0; m_sel = 0; m_pend = 0; m_mask = 0; m_ie = 0;
                m_irq_d = 0; m_vec = 0;
            end else begin
`ifdef INTC_EDGE_EN
                newly = s_irq & ~m_irq_d;
`else
                newly = s_irq;
`endif
                done = 0;
                if (m_phase == 0) begin
                    if (m_ie && lowest(m_pend & m_mask) >= 0) begin
                        m_sel   = lowest(m_pend & m_mask);
                        m_vec   = (32'h3C0 + m_sel * 4) % 1024;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (s_en) begin
                        done[m_sel] = 1'b1;
                        m_phase     = 2;
                    end
                end else if (s_reti) begin
                    m_phase = 0;
                end
                m_pend  = (m_pend & ~done) | newly;
                if (s_iewe) m_ie = s_ied;
                if (s_mwe)  m_mask = s_md;
                m_irq_d = s_irq;
            end
            chk("model int_take", {31'd0, int_take}, {31'd0, m_phase == 1});
            chk("model in_service", {31'd0, in_service}, {31'd0, m_phase == 2});
            chk("model pending", {28'd0, pending}, {28'd0, m_pend});
            if (m_phase == 1) chk("model int_vector", {22'd0, int_vector}, m_vec);
        end
    end

    initial begin
        reset = 1; irq = 4'hF; enable_pc = 1; reti = 0;
        ie_we = 0; ie_wdata = 0; mask_we = 0; mask_wdata = 0;
        nxt(); chk("reset pending hold", {28'd0, pending}, 0);
        nxt();
        chk("reset take", {31'd0, int_take}, 0);
        chk("reset vector", {22'd0, int_vector}, 0);
        chk("reset in_service", {31'd0, in_service}, 0);
        chk("reset pending", {28'd0, pending}, 0);
        reset = 0; irq = 0; ie_we = 1; ie_wdata = 1; mask_we = 1; mask_wdata = 4'hF;
        nxt(); ie_we = 0; mask_we = 0;

        // single pulse on irq[2]
        irq = 4'b0100; nxt(); irq = 0;
        chk("t2 pending", {28'd0, pending}, 4'b0100);
        chk("t2 no early take", {31'd0, int_take}, 0);
        nxt();
        chk("t2 take", {31'd0, int_take}, 1);
        chk("t2 vector", {22'd0, int_vector}, 10'h3C8);
        nxt();
        chk("t2 in_service", {31'd0, in_service}, 1);
        chk("t2 pending cleared", {28'd0, pending}, 0);
        reti = 1; nxt(); reti = 0;
        chk("t2 reti", {31'd0, in_service}, 0);

        // simultaneous irq1 and irq3
        irq = 4'b1010; nxt(); irq = 0;
        chk("t3 pending", {28'd0, pending}, 4'b1010);
        nxt();
        chk("t3 first vector", {22'd0, int_vector}, 10'h3C4);
        nxt();
        chk("t3 pending left", {28'd0, pending}, 4'b1000);
        reti = 1; nxt(); reti = 0;
        chk("t3 idle after reti", {31'd0, int_take}, 0);
        nxt();
        chk("t3 second take", {31'd0, int_take}, 1);
        chk("t3 second vector", {22'd0, int_vector}, 10'h3CC);
        nxt(); reti = 1; nxt(); reti = 0;
        reti = 1; nxt(); reti = 0;
        chk("reti in idle ignored", {31'd0, in_service}, 0);

        // stall during TAKE, plus ie/mask cleared mid-take
        irq = 4'b0001; nxt(); irq = 0;
        nxt();
        chk("t4 take", {31'd0, int_take}, 1);
        enable_pc = 0; ie_we = 1; ie_wdata = 0; mask_we = 1; mask_wdata = 0;
        nxt(); ie_we = 0; mask_we = 0;
        chk("t4 held 2", {31'd0, int_take}, 1);
        chk("t4 pending held", {28'd0, pending}, 4'b0001);
        nxt();
        chk("t4 held 3", {31'd0, int_take}, 1);
        nxt();
        chk("t4 held 4", {31'd0, int_take}, 1);
        chk("t4 vector held", {22'd0, int_vector}, 10'h3C0);
        chk("t4 pending still", {28'd0, pending}, 4'b0001);
        enable_pc = 1;
        nxt();
        chk("t4 in_service", {31'd0, in_service}, 1);
        chk("t4 pending cleared", {28'd0, pending}, 0);
        reti = 1; ie_we = 1; ie_wdata = 1;
        nxt(); reti = 0; ie_we = 0;

        // masked request, then unmask
        mask_we = 1; mask_wdata = 4'b0001; irq = 4'b1000;
        nxt(); mask_we = 0; irq = 0;
        nxt(); nxt();
        chk("t5 masked no take", {31'd0, int_take}, 0);
        chk("t5 pending kept", {28'd0, pending}, 4'b1000);
        mask_we = 1; mask_wdata = 4'b1000;
        nxt(); mask_we = 0;
        chk("t5 old mask used", {31'd0, int_take}, 0);
        nxt();
        chk("t5 take", {31'd0, int_take}, 1);
        chk("t5 vector", {22'd0, int_vector}, 10'h3CC);
        nxt(); reti = 1; nxt(); reti = 0;

        // irq[0] held high across an ISR
        mask_we = 1; mask_wdata = 4'hF; nxt(); mask_we = 0;
        irq = 4'b0001; nxt();
        chk("t6 pending", {28'd0, pending}, 4'b0001);
        nxt();
        chk("t6 take", {31'd0, int_take}, 1);
        chk("t6 vector", {22'd0, int_vector}, 10'h3C0);
        nxt();
`ifdef INTC_EDGE_EN
        chk("t6 pending edge", {28'd0, pending}, 0);
`else
        chk("t6 pending level", {28'd0, pending}, 4'b0001);
`endif
        reti = 1; nxt(); reti = 0;
        nxt();
`ifdef INTC_EDGE_EN
        chk("t6 no retake", {31'd0, int_take}, 0);
`else
        chk("t6 retake", {31'd0, int_take}, 1);
        chk("t6 retake vector", {22'd0, int_vector}, 10'h3C0);
`endif
        irq = 0; nxt();
`ifndef INTC_EDGE_EN
        chk("t6 second isr", {31'd0, in_service}, 1);
`endif
        reset = 1; nxt(); reset = 0;
        chk("t6 reset take", {31'd0, int_take}, 0);
        chk("t6 reset svc", {31'd0, in_service}, 0);
        chk("t6 reset pending", {28'd0, pending}, 0);

        // reset in TAKE
        ie_we = 1; ie_wdata = 1; mask_we = 1; mask_wdata = 4'hF; irq = 4'b0010;
        nxt(); ie_we = 0; mask_we = 0; irq = 0;
        nxt();
        chk("rt take", {31'd0, int_take}, 1);
        chk("rt vector", {22'd0, int_vector}, 10'h3C4);
        reset = 1; nxt(); reset = 0;
        chk("rt aborted", {31'd0, int_take}, 0);
        chk("rt vector cleared", {22'd0, int_vector}, 0);

        // reset in SERVICE
        ie_we = 1; ie_wdata = 1; mask_we = 1; mask_wdata = 4'hF; irq = 4'b0010;
        nxt(); ie_we = 0; mask_we = 0; irq = 0;
        nxt(); nxt();
        chk("rs in_service", {31'd0, in_service}, 1);
        reset = 1; nxt(); reset = 0;
        chk("rs cleared", {31'd0, in_service}, 0);
        nxt(); nxt(); nxt();
        chk("rs stays idle", {31'd0, int_take}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
